// File: rtl/fpio_pkg.sv
// Shared definitions for fpio channel blocks: width helpers and
// configuration sanity functions used at elaboration time.
package fpio_pkg;

  // Width needed to hold an occupancy value in the range 0..depth.
  function automatic int fpio_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Storage depth must be a power of two so pointers wrap naturally.
  function automatic bit fpio_depth_ok(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // Almost-full threshold must lie within 1..depth.
  function automatic bit fpio_afull_ok(input int depth, input int level);
    return (level >= 1) && (level <= depth);
  endfunction

endpackage

// File: rtl/fpio_fifo_if.sv
// fpio valid/ready data channel: DAT qualified by DAT_v, accepted by DAT_r.
interface fpio_fifo_if #(
  parameter int DATA_WIDTH = 4
);
  logic [DATA_WIDTH-1:0] DAT;
  logic                  DAT_v;
  logic                  DAT_r;

  // Producer side drives data and valid; consumer side drives ready.
  modport master (output DAT, output DAT_v, input DAT_r);
  modport slave  (input DAT, input DAT_v, output DAT_r);
endinterface

// File: rtl/fpio_fifo_mem.sv
// Storage array for fpio_fifo: synchronous write, asynchronous read, no reset.
module fpio_fifo_mem #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] store [DEPTH];

  // Write the addressed entry on an accepted push; contents are never cleared.
  always_ff @(posedge clock) begin
    if (we) store[waddr] <= wdata;
  end

  assign rdata = store[raddr];

endmodule

// File: rtl/fpio_fifo.sv
// Parametrised fpio buffering stage: in-order FIFO between an fpio producer
// and consumer, with occupancy status. Input ready depends only on
// registered state and reset, never on the output ready.
module fpio_fifo
  import fpio_pkg::*;
#(
  parameter int DATA_WIDTH  = 4,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = DEPTH - 1
) (
  input  logic                             clock,
  input  logic                             reset,
  fpio_fifo_if.slave                       in_ch,
  fpio_fifo_if.master                      out_ch,
  output logic [fpio_cnt_width(DEPTH)-1:0] count,
  output logic                             full,
  output logic                             empty,
  output logic                             afull
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = fpio_cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LEVEL);

  if (!fpio_depth_ok(DEPTH)) begin : g_bad_depth
    $error("fpio_fifo: DEPTH must be a power of 2 and >= 2");
  end
  if (!fpio_afull_ok(DEPTH, AFULL_LEVEL)) begin : g_bad_afull
    $error("fpio_fifo: AFULL_LEVEL must be within 1..DEPTH");
  end

  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count_q;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  push;
  logic                  pop;

  // Status decodes straight from the registered occupancy.
  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign afull = (count_q >= AFULL_C);
  assign count = count_q;

  assign in_ch.DAT_r  = !full && !reset;
  assign out_ch.DAT_v = !empty;
  assign out_ch.DAT   = rdata;

  assign push = in_ch.DAT_v && in_ch.DAT_r;
  assign pop  = out_ch.DAT_v && out_ch.DAT_r;

  fpio_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clock (clock),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_ch.DAT),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Advance pointers on each transfer and track occupancy; reset empties the FIFO.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fpio_fifo.sv
// Directed bench for fpio_fifo: a DEPTH=4/4-bit instance for the directed
// scenarios and a DEPTH=16/8-bit instance for the back-pressure stream.
module tb_fpio_fifo;

  logic clock;
  logic reset;

  fpio_fifo_if #(.DATA_WIDTH(4)) a_in  ();
  fpio_fifo_if #(.DATA_WIDTH(4)) a_out ();
  fpio_fifo_if #(.DATA_WIDTH(8)) b_in  ();
  fpio_fifo_if #(.DATA_WIDTH(8)) b_out ();

  logic [2:0] a_count;
  logic       a_full, a_empty, a_afull;
  logic [4:0] b_count;
  logic       b_full, b_empty, b_afull;

  fpio_fifo #(.DATA_WIDTH(4), .DEPTH(4), .AFULL_LEVEL(3)) u_a (
    .clock  (clock),
    .reset  (reset),
    .in_ch  (a_in),
    .out_ch (a_out),
    .count  (a_count),
    .full   (a_full),
    .empty  (a_empty),
    .afull  (a_afull)
  );

  fpio_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_LEVEL(15)) u_b (
    .clock  (clock),
    .reset  (reset),
    .in_ch  (b_in),
    .out_ch (b_out),
    .count  (b_count),
    .full   (b_full),
    .empty  (b_empty),
    .afull  (b_afull)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [7:0] sb_q[$];

  initial begin
    logic [3:0] fill_val [4];
    bit         rin_v, rout_r, push_m, pop_m;
    logic [7:0] rdat;

    a_in.DAT = '0;  a_in.DAT_v = 1'b0;  a_out.DAT_r = 1'b0;
    b_in.DAT = '0;  b_in.DAT_v = 1'b0;  b_out.DAT_r = 1'b0;

    // Reset then idle
    reset = 1'b1;
    step();
    step();
    check("rst_in_r_low", a_in.DAT_r, 0);
    check("rst_count", a_count, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle_count", a_count, 0);
      check("idle_empty", a_empty, 1);
      check("idle_out_v", a_out.DAT_v, 0);
      check("idle_in_r", a_in.DAT_r, 1);
      check("idle_full", a_full, 0);
      check("idle_afull", a_afull, 0);
    end

    // Fill with out_DAT_r low
    a_in.DAT_v = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      a_in.DAT = 4'(i);
      step();
      check("fill_count", a_count, i);
      check("fill_head", a_out.DAT, 1);
      check("fill_out_v", a_out.DAT_v, 1);
      check("fill_afull", a_afull, (i >= 3) ? 1 : 0);
      check("fill_full", a_full, (i == 4) ? 1 : 0);
      check("fill_in_r", a_in.DAT_r, (i == 4) ? 0 : 1);
    end
    a_in.DAT = 4'h5;
    step();
    check("over_count", a_count, 4);
    check("over_head", a_out.DAT, 1);
    a_in.DAT_v = 1'b0;

    // Drain in order
    a_out.DAT_r = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain_v", a_out.DAT_v, 1);
      check("drain_dat", a_out.DAT, i);
      step();
    end
    check("drain_empty", a_empty, 1);
    check("drain_out_v", a_out.DAT_v, 0);
    check("drain_count", a_count, 0);

    // Steady stream 0..31 with both sides always ready
    a_in.DAT_v = 1'b1;
    for (int i = 0; i < 32; i++) begin
      a_in.DAT = 4'(i);
      if (i == 0) check("stream_latency_v", a_out.DAT_v, 0);
      step();
      check("stream_dat", a_out.DAT, i & 15);
      check("stream_count", a_count, 1);
    end
    a_in.DAT_v = 1'b0;
    step();
    check("stream_end_empty", a_empty, 1);
    a_out.DAT_r = 1'b0;

    // Full with simultaneous pop: no push on that edge
    fill_val[0] = 4'h6; fill_val[1] = 4'h7; fill_val[2] = 4'h8; fill_val[3] = 4'h9;
    a_in.DAT_v = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in.DAT = fill_val[i];
      step();
    end
    check("fp_full", a_full, 1);
    a_in.DAT = 4'hE;
    a_out.DAT_r = 1'b1;
    check("fp_in_r_low", a_in.DAT_r, 0);
    step();
    check("fp_count3", a_count, 3);
    check("fp_in_r_back", a_in.DAT_r, 1);
    check("fp_head", a_out.DAT, 7);
    a_out.DAT_r = 1'b0;
    step();
    check("fp_push_count", a_count, 4);
    a_in.DAT_v = 1'b0;
    a_out.DAT_r = 1'b1;
    check("fp_drain0", a_out.DAT, 7); step();
    check("fp_drain1", a_out.DAT, 8); step();
    check("fp_drain2", a_out.DAT, 9); step();
    check("fp_drain3", a_out.DAT, 4'hE); step();
    check("fp_empty", a_empty, 1);
    a_out.DAT_r = 1'b0;

    // Random back-pressure on the 16-deep instance
    for (int c = 0; c < 2000; c++) begin
      rin_v  = 1'($urandom_range(0, 1));
      rout_r = 1'($urandom_range(0, 1));
      rdat   = 8'($urandom_range(0, 255));
      b_in.DAT_v  = rin_v;
      b_in.DAT    = rdat;
      b_out.DAT_r = rout_r;
      push_m = rin_v && (sb_q.size() < 16);
      pop_m  = rout_r && (sb_q.size() > 0);
      #1;
      check("rnd_in_r", b_in.DAT_r, (sb_q.size() < 16) ? 1 : 0);
      check("rnd_out_v", b_out.DAT_v, (sb_q.size() > 0) ? 1 : 0);
      if (pop_m) check("rnd_dat", b_out.DAT, sb_q[0]);
      step();
      if (pop_m)  void'(sb_q.pop_front());
      if (push_m) sb_q.push_back(rdat);
      check("rnd_count", b_count, sb_q.size());
    end
    b_in.DAT_v = 1'b0;
    b_out.DAT_r = 1'b0;

    // Reset mid-operation with three words held
    a_in.DAT_v = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      a_in.DAT = 4'(i);
      step();
    end
    a_in.DAT_v = 1'b0;
    check("mid_count3", a_count, 3);
    reset = 1'b1;
    step();
    check("mid_rst_count", a_count, 0);
    check("mid_rst_out_v", a_out.DAT_v, 0);
    check("mid_rst_in_r", a_in.DAT_r, 0);
    reset = 1'b0;
    #1;
    check("mid_in_r_after", a_in.DAT_r, 1);
    a_in.DAT_v = 1'b1;
    a_in.DAT = 4'hA;
    step();
    a_in.DAT_v = 1'b0;
    check("mid_first_v", a_out.DAT_v, 1);
    check("mid_first_dat", a_out.DAT, 4'hA);
    check("mid_first_count", a_count, 1);
    a_out.DAT_r = 1'b1;
    step();
    check("mid_no_stale", a_out.DAT_v, 0);
    a_out.DAT_r = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fpio_fifo.md
Name: fpio_fifo

Overview:
- Parametrised buffering stage for the fpio valid/ready data channel (DAT / DAT_v / DAT_r).
- Accepts words on a receive-side fpio channel and presents them in order on a transmit-side fpio channel.
- Generalises depth and adds occupancy status, which the bare channel lacks.
- Sits between any fpio producer and consumer to decouple rate and back-pressure. No combinational path from the output ready to the input ready.

Parameters:
- DATA_WIDTH, 4, width of DAT on both sides.
- DEPTH, 4, number of storage entries. Must be a power of 2 and >= 2.
- AFULL_LEVEL, DEPTH-1, occupancy at or above which afull asserts. Range 1..DEPTH.

Ports:
- clock  input  1  single clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_DAT  input  DATA_WIDTH  receive-side data.
- in_DAT_v  input  1  receive-side valid.
- in_DAT_r  output  1  receive-side ready.
- out_DAT  output  DATA_WIDTH  transmit-side data.
- out_DAT_v  output  1  transmit-side valid.
- out_DAT_r  input  1  transmit-side ready.
- count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- afull  output  1  count >= AFULL_LEVEL.

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Transfers:
  - push = in_DAT_v & in_DAT_r.
  - pop = out_DAT_v & out_DAT_r.
  - Each transfer completes on the rising clock edge where its condition holds.
- in_DAT_r = !full & !reset. It is a function of registered state and reset only, never of out_DAT_r.
- out_DAT_v = !empty. out_DAT = entry at read pointer.
- Ordering and stability: strict FIFO order. out_DAT and out_DAT_v stay stable until pop.
- Latency: a word pushed into an empty FIFO at edge N is visible on out_DAT with out_DAT_v=1 after edge N. There is no same-cycle fall-through.
- Pointers: rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally DEPTH-1 -> 0. count is kept as a separate register.
- Occupancy updates per edge:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged, both pointers advance.
- Boundaries:
  - Empty: pop is impossible (out_DAT_v=0). A push makes count=1.
  - Empty with simultaneous push: no bypass. The word appears the next cycle.
  - Full: in_DAT_r=0, so no push. A pop makes count=DEPTH-1 and in_DAT_r=1 the next cycle.
  - Full with out_DAT_r=1: the pop happens. The producer may not push in that same cycle.
  - in_DAT_v while in_DAT_r=0: ignored, no state change.
- Reset behaviour (also mid-operation):
  - At the edge: rd_ptr=0, wr_ptr=0, count=0.
  - Contents are discarded. Storage is not cleared.
  - After reset: out_DAT_v=0, empty=1, full=0, afull=0 (AFULL_LEVEL>=1). in_DAT_r=0 while reset is high and 1 after.
  - out_DAT is don't-care while out_DAT_v=0.
- Status outputs are registered-state decodes and are valid in the same cycle as count.

Decomposition:
- Package fpio_pkg:
  - function fpio_cnt_width(depth) returning $clog2(depth)+1.
  - localparam-style elaboration checks: DEPTH power of 2, AFULL_LEVEL range.
  - Shared by future fpio blocks.
- Sub-module fpio_fifo_mem:
  - DATA_WIDTH x DEPTH storage array.
  - Synchronous write port (we, waddr, wdata).
  - Asynchronous read port (raddr, rdata).
  - No reset.
- fpio_fifo holds pointers, count, handshake and status logic.

Test Plan:
- Reset then idle (DEPTH=4): after reset deasserts, expect count=0, empty=1, out_DAT_v=0, in_DAT_r=1, held for 10 cycles.
- Fill/drain, out_DAT_r=0: push 0x1,0x2,0x3,0x4 on consecutive cycles.
  - Expect afull after the 3rd push, full=1 and in_DAT_r=0 after the 4th.
  - A 5th in_DAT_v with 0x5 is not accepted.
  - Then out_DAT_r=1: expect 0x1..0x4 in order on 4 consecutive cycles, then empty=1.
- Steady stream: in_DAT_v=1 and out_DAT_r=1 continuously with an incrementing pattern 0..31.
  - Expect 1-cycle initial latency, then one word per cycle with count constant at 1.
  - Pointers wrap 8 times with no loss or reorder.
- Full with simultaneous pop: from full, hold out_DAT_r=1 with in_DAT_v=1.
  - Expect a pop that edge with no push.
  - Next cycle count=3 and in_DAT_r=1, then push accepted.
- Random back-pressure: random in_DAT_v and out_DAT_r over 2000 cycles, DATA_WIDTH=8, DEPTH=16.
  - Scoreboard matches in order.
  - count always equals pushes minus pops and never exceeds 16.
- Reset mid-operation: with count=3, assert reset for 1 cycle.
  - Next cycle count=0 and out_DAT_v=0.
  - A subsequent push of 0xA appears as the first output; no stale words.
